// File: rtl/agc_gain_ctrl.sv
// agc_gain_ctrl: peak-tracking gain controller with fast attack, hold and slow release, plus clip counting
module agc_gain_ctrl #(
  parameter int FRAC_BITS = 16,
  parameter logic [31:0] GAIN_INIT = 32'h0001_0000,
  parameter logic [31:0] GAIN_MIN = 32'h0000_1000,
  parameter logic [31:0] GAIN_MAX = 32'h0010_0000,
  parameter int ATTACK_SHIFT = 2,
  parameter logic [31:0] RELEASE_STEP = 32'h0000_0100,
  parameter int HOLD_CNT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [31:0] in_data,
  input  logic [31:0] threshold,
  output logic [31:0] gain,
  output logic gain_valid,
  output logic [1:0] agc_state,
  output logic clip,
  output logic [15:0] clip_count,
  input  logic clip_clr
);
  localparam int HW = $clog2(HOLD_CNT + 1);
  typedef enum logic [1:0] {HOLD = 2'd0, ATTACK = 2'd1, RELEASE = 2'd2} state_t;
  state_t state, next_state;
  logic s1_v, s2_v;
  logic [31:0] s1_mag, att, att_gain, rel_gain, rel_thr, next_gain;
  logic [32:0] rel_sum;
  logic [63:0] prod;
  logic [47:0] level, s2_level;
  logic [HW-1:0] hold, next_hold;
  logic over, under, clip_hit;
  assign in_ready = !rst;
  assign agc_state = state;
  assign prod = {32'd0, s1_mag} * {32'd0, gain};
  assign level = 48'(prod >> FRAC_BITS);
  always_comb begin
    att = gain - (gain >> ATTACK_SHIFT);
    att_gain = att < GAIN_MIN ? GAIN_MIN : att;
    rel_sum = {1'b0, gain} + {1'b0, RELEASE_STEP};
    rel_gain = rel_sum > {1'b0, GAIN_MAX} ? GAIN_MAX : rel_sum[31:0];
    rel_thr = threshold - (threshold >> 3);
    over = s2_level > {16'd0, threshold};
    under = s2_level < {16'd0, rel_thr};
    clip_hit = s2_level > 48'h0000_7FFF_FFFF;
    next_gain = over ? att_gain : (hold != '0 || !under) ? gain : rel_gain;
    next_state = over ? ATTACK : (hold != '0 || !under) ? HOLD : RELEASE;
    next_hold = over ? HW'(HOLD_CNT) : hold != '0 ? hold - HW'(1) : hold;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_mag <= '0;
      s2_level <= '0;
      gain <= GAIN_INIT;
      hold <= HW'(HOLD_CNT);
      state <= HOLD;
      gain_valid <= 1'b0;
      clip <= 1'b0;
      clip_count <= '0;
    end else begin
      s1_v <= in_valid;
      if (in_valid) s1_mag <= in_data[31] ? 32'd0 - in_data : in_data;
      s2_v <= s1_v;
      if (s1_v) s2_level <= level;
      gain_valid <= s2_v && next_gain != gain;
      clip <= s2_v && clip_hit;
      if (s2_v) begin
        gain <= next_gain;
        state <= next_state;
        hold <= next_hold;
      end
      clip_count <= clip_clr ? '0 : (s2_v && clip_hit && clip_count != 16'hFFFF) ? clip_count + 16'd1 : clip_count;
    end
  end
endmodule

// File: tb/tb_agc_gain_ctrl.sv
// tb_agc_gain_ctrl: scoreboard bench; driver pushes model predictions, monitor checks them at the evaluation cycle
module tb_agc_gain_ctrl;
  logic clk = 0, rst = 1, in_valid = 0, clip_clr = 0;
  logic in_ready, gain_valid, clip;
  logic [31:0] in_data = 0, threshold = 0, gain;
  logic [1:0] agc_state;
  logic [15:0] clip_count;
  int cyc = 0, n_chk = 0, n_fail = 0;

  typedef struct {int due; longint g; int st; bit gv; bit cl; int cc;} exp_t;
  exp_t q[$];
  longint mg, mg_prev;
  int mh, mcc, last_c;

  agc_gain_ctrl dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .threshold(threshold), .gain(gain), .gain_valid(gain_valid), .agc_state(agc_state), .clip(clip),
    .clip_count(clip_count), .clip_clr(clip_clr));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", n, cyc, act, req);
    end
  endtask

  // Reference: level uses the gain in force when the sample reaches the multiplier, which is
  // the pre-update gain if the previous sample was accepted on the immediately preceding edge.
  function automatic void model_push(input int c, input logic [31:0] d, input bit clr);
    longint sd, mag, lvl, t, used, ng;
    exp_t e;
    sd = $signed(d);
    mag = sd < 0 ? -sd : sd;
    used = (c - last_c == 1) ? mg_prev : mg;
    lvl = (mag * used) >> 16;
    t = threshold;
    mg_prev = mg;
    last_c = c;
    ng = mg;
    if (lvl > t) begin
      ng = mg - mg / 4;
      if (ng < 64'h1000) ng = 64'h1000;
      mh = 1024;
      e.st = 1;
    end else if (mh > 0) begin
      mh--;
      e.st = 0;
    end else if (lvl < t - t / 8) begin
      ng = (mg + 256 > 64'h10_0000) ? 64'h10_0000 : mg + 256;
      e.st = 2;
    end else e.st = 0;
    e.gv = ng != mg;
    e.cl = lvl > 64'h7FFF_FFFF;
    mg = ng;
    mcc = clr ? 0 : (e.cl && mcc < 65535) ? mcc + 1 : mcc;
    e.due = c + 2;
    e.g = mg;
    e.cc = mcc;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() > 0 && q[0].due < cyc) begin
      e = q.pop_front();
      chk("missed_eval", cyc, e.due);
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("gain", gain, e.g);
      chk("agc_state", agc_state, e.st);
      chk("gain_valid", gain_valid, e.gv);
      chk("clip", clip, e.cl);
      chk("clip_count", clip_count, e.cc);
    end else begin
      chk("idle_gain_valid", gain_valid, 0);
      chk("idle_clip", clip, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input bit clr = 0);
    in_valid = 1;
    in_data = d;
    model_push(cyc + 1, d, clr);
    step();
    in_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    chk("drain_pending", q.size(), 0);
    step();
  endtask

  task automatic do_reset();
    rst = 1;
    in_valid = 0;
    clip_clr = 0;
    while (q.size() > 0 && q[q.size() - 1].due >= cyc + 1) void'(q.pop_back());
    step();
    step();
    chk("in_ready_rst", in_ready, 0);
    rst = 0;
    mg = 64'h1_0000;
    mg_prev = mg;
    mh = 1024;
    mcc = 0;
    last_c = -100;
    step();
  endtask

  task automatic chk_reset_vals();
    chk("rst_gain", gain, 32'h0001_0000);
    chk("rst_state", agc_state, 0);
    chk("rst_gain_valid", gain_valid, 0);
    chk("rst_clip", clip, 0);
    chk("rst_clip_count", clip_count, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    do_reset();
    repeat (5) step();
    chk_reset_vals();
    // single attack
    threshold = 32'h2000_0000;
    send(32'h4000_0000);
    drain();
    chk("attack_gain", gain, 32'h0000_C000);
    chk("attack_state", agc_state, 1);
    // clip event on a full-scale negative sample
    do_reset();
    threshold = 32'h7FFF_FFFF;
    send(32'h8000_0000);
    drain();
    chk("clip_gain", gain, 32'h0000_C000);
    chk("clip_count_one", clip_count, 1);
    // hold then release up to GAIN_MAX
    do_reset();
    threshold = 32'h2000_0000;
    send(32'h4000_0000);
    drain();
    threshold = 32'h1000_0000;
    repeat (1024 + 3904 + 20) send(32'h0);
    drain();
    chk("release_gain", gain, 32'h0010_0000);
    chk("release_state", agc_state, 2);
    // geometric decay to GAIN_MIN
    threshold = 32'h1;
    repeat (60) send(32'h7FFF_FFFF);
    drain();
    chk("decay_gain", gain, 32'h0000_1000);
    // randomized bursts, threshold changed only with an empty pipeline
    for (int b = 0; b < 30; b++) begin
      threshold = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom >> $urandom_range(0, 31);
      for (int i = 0; i < 50; i++) begin
        if ($urandom_range(0, 9) < 7) send(($urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0) ^ ($urandom >> $urandom_range(0, 31)));
        else step();
      end
      drain();
    end
    // clip_clr coinciding with a clip, then saturate the counter
    do_reset();
    threshold = 32'hFFFF_FFFF;
    repeat (3) send(32'h8000_0000);
    drain();
    chk("clip_count_three", clip_count, 3);
    repeat (3) step();
    clip_clr = 1;
    send(32'h8000_0000, 1);
    repeat (4) step();
    clip_clr = 0;
    chk("clip_clr_result", clip_count, 0);
    repeat (65540) send(32'h8000_0000);
    drain();
    chk("clip_saturated", clip_count, 16'hFFFF);
    // reset with samples in flight
    threshold = 32'h1;
    repeat (3) send(32'h7FFF_FFFF);
    do_reset();
    repeat (5) step();
    chk_reset_vals();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
